// File: rtl/cpu4_pkg.sv
// Shared definitions for simple_4bit_cpu: opcode/ALU-function constants, FSM states,
// and the fixed run-mode program.
package cpu4_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam logic [1:0] OP_ALU   = 2'b11;

    localparam logic [1:0] FN_ADD = 2'b00;
    localparam logic [1:0] FN_SUB = 2'b01;
    localparam logic [1:0] FN_AND = 2'b10;
    localparam logic [1:0] FN_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_DONE
    } state_t;

    function automatic logic [7:0] rom_word(input logic [3:0] addr);
        logic [7:0] w;
        case (addr)
            4'd0:    w = 8'b00000011;
            4'd1:    w = 8'b00010010;
            4'd2:    w = 8'b11000100;
            4'd3:    w = 8'b01000100;
            4'd4:    w = 8'b10100000;
            4'd5:    w = 8'b11100101;
            default: w = 8'b00000000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cpu4_alu.sv
// Combinational 4-bit ALU for simple_4bit_cpu; results wrap mod 16, no flags.
module cpu4_alu
    import cpu4_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [1:0] fn_i,
    output logic [3:0] y_o
);

    always_comb begin
        y_o = '0;
        case (fn_i)
            FN_ADD:  y_o = a_i + b_i;
            FN_SUB:  y_o = a_i - b_i;
            FN_AND:  y_o = a_i & b_i;
            FN_OR:   y_o = a_i | b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/simple_4bit_cpu.sv
// Minimal 4-bit CPU: IDLE->FETCH->EXEC->DONE sequencer, 4 GPRs, 4-word RAM, LED register.
// Define CPU_RUN_MODE_EN to add the program ROM, PC and run mode; otherwise always manual.
module simple_4bit_cpu
    import cpu4_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       execute,
    input  logic       switch_mode,
    input  logic       pc_enable,
    input  logic [7:0] instruction,
    output logic [3:0] LEDs,
    output logic       Done
);

    state_t            state_q, state_d;
    logic              exec_prev_q;
    logic [7:0]        ir_q, ir_d;
    logic [3:0][3:0]   regs_q, regs_d;
    logic [3:0][3:0]   ram_q, ram_d;
    logic [3:0]        leds_q, leds_d;
    logic              exec_rise;
    logic              manual;
    logic [7:0]        fetch_word;
    logic [3:0]        alu_y;

    logic [1:0] op, rx, ry, fn;
    logic [3:0] imm;

    assign op  = ir_q[7:6];
    assign rx  = ir_q[5:4];
    assign ry  = ir_q[3:2];
    assign fn  = ir_q[1:0];
    assign imm = ir_q[3:0];

    assign exec_rise = execute & ~exec_prev_q;

`ifdef CPU_RUN_MODE_EN
    logic [3:0] pc_q, pc_d;

    assign manual     = switch_mode;
    assign fetch_word = manual ? instruction : rom_word(pc_q);
`else
    logic unused_cfg;

    assign unused_cfg = ^{switch_mode, pc_enable};
    assign manual     = 1'b1;
    assign fetch_word = instruction;
`endif

    cpu4_alu u_alu (
        .a_i  (regs_q[rx]),
        .b_i  (regs_q[ry]),
        .fn_i (fn),
        .y_o  (alu_y)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        regs_d  = regs_q;
        ram_d   = ram_q;
        leds_d  = leds_q;
`ifdef CPU_RUN_MODE_EN
        pc_d    = pc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (exec_rise) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ir_d    = fetch_word;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (op)
                    OP_LOAD: begin
                        regs_d[rx] = imm;
                        leds_d     = imm;
                    end
                    OP_STORE: begin
                        ram_d[ry] = regs_q[rx];
                        leds_d    = regs_q[rx];
                    end
                    OP_MOVE: begin
                        regs_d[rx] = regs_q[ry];
                        leds_d     = regs_q[ry];
                    end
                    default: begin
                        regs_d[rx] = alu_y;
                        leds_d     = alu_y;
                    end
                endcase
`ifdef CPU_RUN_MODE_EN
                if (!manual && pc_enable) pc_d = pc_q + 4'd1;
`endif
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // Manual waits for release so a held button never re-executes;
                // run mode keeps stepping while execute stays high.
                if (manual) begin
                    if (!execute) state_d = ST_IDLE;
                end else begin
                    state_d = execute ? ST_FETCH : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            exec_prev_q <= 1'b0;
            ir_q        <= '0;
            regs_q      <= '0;
            ram_q       <= '0;
            leds_q      <= '0;
`ifdef CPU_RUN_MODE_EN
            pc_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            exec_prev_q <= execute;
            ir_q        <= ir_d;
            regs_q      <= regs_d;
            ram_q       <= ram_d;
            leds_q      <= leds_d;
`ifdef CPU_RUN_MODE_EN
            pc_q        <= pc_d;
`endif
        end
    end

    assign LEDs = leds_q;
    assign Done = (state_q == ST_DONE);

endmodule

// File: tb/tb_simple_4bit_cpu.sv
// Scoreboard bench for simple_4bit_cpu: expected LED values are queued at issue time and
// popped by a monitor on every rising edge of Done.
module tb_simple_4bit_cpu;

    logic       clk = 1'b0;
    logic       reset;
    logic       execute;
    logic       switch_mode;
    logic       pc_enable;
    logic [7:0] instruction;
    logic [3:0] LEDs;
    logic       Done;

    simple_4bit_cpu dut (
        .clk         (clk),
        .reset       (reset),
        .execute     (execute),
        .switch_mode (switch_mode),
        .pc_enable   (pc_enable),
        .instruction (instruction),
        .LEDs        (LEDs),
        .Done        (Done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] exp_q[$];
    int         m_reg[4];
    int         m_ram[4];
    int         m_pc;
    logic [7:0] rom_tab[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_reg[i] = 0;
            m_ram[i] = 0;
        end
        m_pc = 0;
    endfunction

    // Reference semantics straight from the instruction table, in integer arithmetic.
    function automatic logic [3:0] model_exec(input logic [7:0] ins);
        int op  = int'(ins[7:6]);
        int x   = int'(ins[5:4]);
        int y   = int'(ins[3:2]);
        int fn  = int'(ins[1:0]);
        int imm = int'(ins[3:0]);
        int res = 0;
        if (op == 0) begin
            m_reg[x] = imm;
            res = imm;
        end else if (op == 1) begin
            m_ram[y] = m_reg[x];
            res = m_reg[x];
        end else if (op == 2) begin
            m_reg[x] = m_reg[y];
            res = m_reg[y];
        end else begin
            if (fn == 0)      res = (m_reg[x] + m_reg[y]) % 16;
            else if (fn == 1) res = (m_reg[x] - m_reg[y] + 16) % 16;
            else if (fn == 2) res = m_reg[x] & m_reg[y];
            else              res = m_reg[x] | m_reg[y];
            m_reg[x] = res;
        end
        return 4'(res);
    endfunction

    // Monitor: each new Done assertion must match the oldest outstanding expectation.
    logic       done_prev = 1'b0;
    logic [3:0] mon_exp;
    always @(negedge clk) begin
        if (Done === 1'b1 && done_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: LEDs=%0d with nothing pending (t=%0t)", LEDs, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                check("leds_result", 32'(LEDs), 32'(mon_exp));
            end
        end
        done_prev = Done;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic do_reset();
        reset = 1'b1;
        execute = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("reset_leds", 32'(LEDs), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
    endtask

    // Manual-mode instruction; called and returns at a negedge with the CPU idle.
    task automatic do_manual(input logic [7:0] ins, input int hold);
        int         lat;
        logic [3:0] e;
        instruction = ins;
        e = model_exec(ins);
        exp_q.push_back(e);
        execute = 1'b1;
        lat = 0;
        while (Done !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check("done_latency", 32'(lat), 32'd3);
        for (int h = 0; h < hold; h++) begin
            instruction = 8'($urandom);
            @(negedge clk);
            check("done_hold", 32'(Done), 32'd1);
            check("leds_hold", 32'(LEDs), 32'(e));
        end
        execute = 1'b0;
        @(negedge clk);
        check("done_release", 32'(Done), 32'd0);
    endtask

`ifdef CPU_RUN_MODE_EN
    task automatic do_run(input int n_instr, input logic pc_en);
        switch_mode = 1'b0;
        pc_enable = pc_en;
        for (int k = 0; k < n_instr; k++) begin
            exp_q.push_back(model_exec(rom_tab[m_pc]));
            if (pc_en) m_pc = (m_pc + 1) % 16;
        end
        execute = 1'b1;
        repeat (3 * n_instr) @(negedge clk);
        check("run_last_done", 32'(Done), 32'd1);
        execute = 1'b0;
        @(negedge clk);
        check("run_idle_done", 32'(Done), 32'd0);
        check("run_queue_drained", 32'(exp_q.size()), 32'd0);
        check("run_pc", 32'(dut.pc_q), 32'(m_pc));
        switch_mode = 1'b1;
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) rom_tab[i] = 8'h00;
        rom_tab[0] = 8'b00000011;
        rom_tab[1] = 8'b00010010;
        rom_tab[2] = 8'b11000100;
        rom_tab[3] = 8'b01000100;
        rom_tab[4] = 8'b10100000;
        rom_tab[5] = 8'b11100101;

        reset = 1'b1;
        execute = 1'b0;
        switch_mode = 1'b1;
        pc_enable = 1'b0;
        instruction = 8'h00;
        repeat (3) @(negedge clk);
        do_reset();

        do_manual(8'b00001010, 0);
        do_manual(8'b00010101, 0);
        do_manual(8'b11000100, 0);

        do_reset();
        do_manual(8'b00001111, 0);
        do_manual(8'b00010001, 0);
        do_manual(8'b01000100, 0);
        check("store_ram1", 32'(dut.ram_q[1]), 32'(m_ram[1]));
        do_manual(8'b10000100, 0);

        do_reset();
        do_manual(8'b00001010, 0);
        do_manual(8'b00010101, 0);
        do_manual(8'b11000110, 0);

        do_reset();
        do_manual(8'b11000111, 0);
        do_manual(8'b00001111, 0);
        do_manual(8'b00010001, 0);
        do_manual(8'b11000100, 0);

        // Held execute: one instruction only; the monitor flags any extra Done.
        do_manual(8'b00100110, 10);

        // Reset while the instruction is in EXEC aborts its writeback.
        do_manual(8'b00101001, 0);
        instruction = 8'b00111100;
        execute = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        check("abort_leds", 32'(LEDs), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        reset = 1'b0;
        execute = 1'b0;
        @(negedge clk);
        check("abort_idle_done", 32'(Done), 32'd0);
        do_manual(8'b10001100, 0);

`ifdef CPU_RUN_MODE_EN
        do_reset();
        do_run(6, 1'b1);
        check("run_ram1", 32'(dut.ram_q[1]), 32'(m_ram[1]));
        do_manual(8'b10110000, 0);
        do_manual(8'b10110100, 0);
        do_manual(8'b10111000, 0);

        do_reset();
        do_run(3, 1'b0);

        do_reset();
        do_run(17, 1'b1);
`endif

        do_reset();
        for (int i = 0; i < 60; i++) begin
`ifndef CPU_RUN_MODE_EN
            switch_mode = 1'($urandom);
            pc_enable = 1'($urandom);
`else
            pc_enable = 1'($urandom);
`endif
            do_manual(8'($urandom), int'($urandom_range(0, 3)));
        end
        check("store_ram_final0", 32'(dut.ram_q[0]), 32'(m_ram[0]));
        check("store_ram_final3", 32'(dut.ram_q[3]), 32'(m_ram[3]));

        repeat (4) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
